// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sequencer.
// Event priorities, ROM entry layout, sequence start addresses and FSM states.
package sfx_pkg;

  typedef enum logic [2:0] {
    PRIO_NONE  = 3'd0,
    PRIO_MOVE  = 3'd1,
    PRIO_MERGE = 3'd2,
    PRIO_WIN   = 3'd3,
    PRIO_LOSE  = 3'd4
  } prio_t;

  typedef struct packed {
    logic       last;
    logic [2:0] dur;
    logic [3:0] tone;
  } rom_entry_t;

  localparam logic [3:0] ADDR_MOVE  = 4'd0;
  localparam logic [3:0] ADDR_MERGE = 4'd1;
  localparam logic [3:0] ADDR_WIN   = 4'd3;
  localparam logic [3:0] ADDR_LOSE  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  function automatic logic [3:0] start_addr(input prio_t p);
    case (p)
      PRIO_LOSE:  start_addr = ADDR_LOSE;
      PRIO_WIN:   start_addr = ADDR_WIN;
      PRIO_MERGE: start_addr = ADDR_MERGE;
      default:    start_addr = ADDR_MOVE;
    endcase
  endfunction

  // Simultaneous events resolve to the most important one only.
  function automatic prio_t event_prio(input logic mv, input logic mg,
                                       input logic w, input logic l);
    if (l)       event_prio = PRIO_LOSE;
    else if (w)  event_prio = PRIO_WIN;
    else if (mg) event_prio = PRIO_MERGE;
    else if (mv) event_prio = PRIO_MOVE;
    else         event_prio = PRIO_NONE;
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Game-event inputs and tone-select outputs of the sound-effect sequencer.
// master = game logic side, slave = sequencer side.
interface sfx_sequencer_if;
  logic       en;
  logic       ev_move;
  logic       ev_merge;
  logic       ev_win;
  logic       ev_lose;
  logic [3:0] tone;
  logic       busy;

  modport master (output en, ev_move, ev_merge, ev_win, ev_lose,
                  input  tone, busy);
  modport slave  (input  en, ev_move, ev_merge, ev_win, ev_lose,
                  output tone, busy);
endinterface

// File: rtl/sfx_rom.sv
// Constant note-sequence table: addr -> {last, dur, tone}.
// Entries beyond the last sequence and beyond ROM_DEPTH read as zero.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int ROM_DEPTH = 16
) (
  input  logic [3:0] addr,
  output rom_entry_t entry
);

  always_comb begin
    entry = '0;
    if (int'(addr) < ROM_DEPTH) begin
      case (addr)
        4'd0:    entry = '{last: 1'b1, dur: 3'd1, tone: 4'b0001};
        4'd1:    entry = '{last: 1'b0, dur: 3'd1, tone: 4'b0010};
        4'd2:    entry = '{last: 1'b1, dur: 3'd1, tone: 4'b0100};
        4'd3:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b0001};
        4'd4:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b0010};
        4'd5:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b0100};
        4'd6:    entry = '{last: 1'b1, dur: 3'd4, tone: 4'b1000};
        4'd7:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b1000};
        4'd8:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b0100};
        4'd9:    entry = '{last: 1'b0, dur: 3'd2, tone: 4'b0010};
        4'd10:   entry = '{last: 1'b1, dur: 3'd4, tone: 4'b0001};
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns one-cycle game events into timed one-hot note sequences for the tone generator.
// Optional macro SFX_PENDING_EN adds a one-deep slot for events that cannot preempt.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int NOTE_TICKS = 5000000,
  parameter int ROM_DEPTH  = 16
) (
  input logic       clk,
  input logic       rst_n,
  sfx_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(7 * NOTE_TICKS);

  state_t           state_reg;
  prio_t            cur_reg;
  logic [3:0]       addr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;
  logic [3:0]       tone_reg;
  logic             busy_reg;

  rom_entry_t       rom_entry;
  prio_t            new_prio;
  prio_t            follow_prio;
  logic [2:0]       dur_eff;
  logic [CNT_W-1:0] cnt_load;

  sfx_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
    .addr  (addr_reg),
    .entry (rom_entry)
  );

  assign new_prio = event_prio(bus.ev_move, bus.ev_merge, bus.ev_win, bus.ev_lose);

  always_comb begin
    dur_eff  = (rom_entry.dur == 3'd0) ? 3'd1 : rom_entry.dur;
    cnt_load = CNT_W'(int'(dur_eff) * NOTE_TICKS - 1);
  end

`ifdef SFX_PENDING_EN
  prio_t pend_reg;
  prio_t pend_merged;
  // An event arriving on the final cycle still competes for the follow-on slot.
  assign pend_merged = (new_prio > pend_reg) ? new_prio : pend_reg;
  assign follow_prio = pend_merged;
`else
  assign follow_prio = PRIO_NONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cur_reg   <= PRIO_NONE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
      tone_reg  <= '0;
      busy_reg  <= 1'b0;
`ifdef SFX_PENDING_EN
      pend_reg  <= PRIO_NONE;
`endif
    end else if (!bus.en) begin
      state_reg <= ST_IDLE;
      cur_reg   <= PRIO_NONE;
      cnt_reg   <= '0;
      tone_reg  <= '0;
      busy_reg  <= 1'b0;
`ifdef SFX_PENDING_EN
      pend_reg  <= PRIO_NONE;
`endif
    end else if (new_prio > cur_reg) begin
      // Idle counts as PRIO_NONE, so starting and preempting share this path.
      state_reg <= ST_FETCH;
      addr_reg  <= start_addr(new_prio);
      cur_reg   <= new_prio;
      tone_reg  <= '0;
      busy_reg  <= 1'b1;
`ifdef SFX_PENDING_EN
      if (pend_reg <= new_prio) pend_reg <= PRIO_NONE;
`endif
    end else begin
`ifdef SFX_PENDING_EN
      pend_reg <= pend_merged;
`endif
      case (state_reg)
        ST_IDLE: begin
          tone_reg <= '0;
          busy_reg <= 1'b0;
        end
        ST_FETCH: begin
          state_reg <= ST_PLAY;
          tone_reg  <= rom_entry.tone;
          last_reg  <= rom_entry.last;
          cnt_reg   <= cnt_load;
        end
        ST_PLAY: begin
          if (cnt_reg == '0) begin
            tone_reg <= '0;
            if (!last_reg) begin
              addr_reg  <= addr_reg + 4'd1;
              state_reg <= ST_FETCH;
            end else if (follow_prio != PRIO_NONE) begin
              state_reg <= ST_FETCH;
              addr_reg  <= start_addr(follow_prio);
              cur_reg   <= follow_prio;
`ifdef SFX_PENDING_EN
              pend_reg  <= PRIO_NONE;
`endif
            end else begin
              state_reg <= ST_IDLE;
              cur_reg   <= PRIO_NONE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cur_reg   <= PRIO_NONE;
          tone_reg  <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone = tone_reg;
  assign bus.busy = busy_reg;

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Upstream stage of the speaker tone generator; replaces raw buttons as the source of its 4-bit one-hot tone select.
- Converts single-cycle game events (move, merge, win, lose) into short timed note sequences held on a one-hot tone code.
- The tone generator maps each one-hot code to a pitch; code 0 means silence.

Parameters:
- NOTE_TICKS, 5000000, clk cycles per duration unit (50 ms at 100 MHz).
- ROM_DEPTH, 16, number of sequence-ROM entries.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sound enable; low aborts playback and ignores events.
- ev_move  in  1  one-cycle pulse: tiles moved.
- ev_merge  in  1  one-cycle pulse: tiles merged.
- ev_win  in  1  one-cycle pulse: 2048 reached.
- ev_lose  in  1  one-cycle pulse: no moves left.
- tone  out  4  one-hot tone select to the tone generator; 0 = rest.
- busy  out  1  high while a sequence is playing.

Behaviour:
- Reset: asynchronous; tone=0, busy=0, state IDLE, counters 0.
- ROM entry is 8 bits: {last, dur[2:0], tone[3:0]}. Note length is dur*NOTE_TICKS cycles. dur=0 is treated as 1.
- Sequences, start addresses fixed:
  - MOVE @0: 0001/d1, last.
  - MERGE @1: 0010/d1, 0100/d1, last.
  - WIN @3: 0001/d2, 0010/d2, 0100/d2, 1000/d4, last.
  - LOSE @7: 1000/d2, 0100/d2, 0010/d2, 0001/d4, last.
  - Addresses 11..15 are unused and read 0.
- Priority, highest first: lose > win > merge > move. Simultaneous events select the highest only.
- States:
  - IDLE: tone=0, busy=0.
  - FETCH: tone=0, busy=1; address register drives the ROM, entry captured.
  - PLAY: tone=entry tone, busy=1; counter counts down.
- IDLE -> FETCH: in the cycle after an event is sampled high with en=1. addr = start address; current priority is stored.
- FETCH -> PLAY: after one cycle. tone becomes valid 2 cycles after the event edge. Counter = dur*NOTE_TICKS-1.
- PLAY: when the counter reaches 0:
  - last=1: go to IDLE.
  - otherwise: addr+1 and go to FETCH. This gives exactly one tone=0 cycle between notes.
- Preemption:
  - An event with strictly higher priority than the playing sequence restarts at its start address via FETCH, whatever the current state or counter.
  - Equal or lower priority events are dropped.
- en low in any state: next cycle state IDLE, tone=0, busy=0. Events arriving while en=0 are lost, never queued.
- Counter width is ceil(log2(7*NOTE_TICKS)). No wrap is possible; the counter only loads and decrements to 0.
- Reset asserted mid-sequence: immediate silence. After release, the sequencer stays in IDLE until a new event.

Optional Feature:
- Macro SFX_PENDING_EN.
- Defined: adds a one-deep pending slot.
  - An equal or lower priority event during playback is stored in the slot; a higher-priority arrival overwrites a lower one held there.
  - At the end of the sequence (last note expires), go to FETCH of the pending sequence instead of IDLE, and clear the slot.
  - Preemption clears the slot only if the pending priority is <= the new one.
  - en low clears the slot.
- Undefined: lower and equal priority events are dropped as described in Behaviour.

Decomposition:
- Package sfx_pkg:
  - event/priority enum (NONE, MOVE, MERGE, WIN, LOSE);
  - ROM entry typedef;
  - start-address constants;
  - state enum.
- Sub-module sfx_rom: combinational lookup, addr[3:0] -> 8-bit entry, table as constants. The FSM, counter and priority logic stay in sfx_sequencer.

Test Plan:
- NOTE_TICKS=4, ev_move pulse at cycle 10 -> busy=1 from cycle 11; tone=0001 for cycles 12..15; tone=0 and busy=0 at cycle 16.
- ev_merge -> tone 0010 for 4 cycles, one 0 cycle, 0100 for 4 cycles, then IDLE; busy high for 10 cycles total.
- ev_move and ev_lose asserted together -> LOSE plays: 1000 for 8 cycles, 0100 for 8, 0010 for 8, 0001 for 16.
- During WIN's second note, pulse ev_lose -> next cycle FETCH (tone=0), then 1000. A later ev_merge is ignored and the LOSE sequence completes unchanged.
- en dropped mid-WIN -> tone=0 and busy=0 on the next edge; ev_move while en=0 -> no output.
- rst_n low for 3 cycles mid-LOSE -> tone=0 immediately (asynchronous); idle after release. With SFX_PENDING_EN, ev_move during MERGE -> MOVE's 0001 follows MERGE after one 0 cycle.
